cmlink_tx_serializer: RTL and testbench

Camera Link Base-configuration transmitter core running entirely on the 7x bit clock. Each pixel period is 7 bit-clock cycles. The block samples one 28-bit Channel Link word per period from ports A/B/C and FVAL/LVAL/DVAL. It then shifts the word out MSB-first on four data lanes, alongside a clock lane carrying the 1100011 pattern. Downstream LVDS buffers and upstream pixel sources (test pattern generator) attach outside this block.

---
 rtl/cmlink_pkg.sv | 41 ++++
 rtl/cmlink_lane_ser.sv | 28 ++
 rtl/cmlink_tx_serializer.sv | 68 ++++++
 tb/tb_cmlink_tx_serializer.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/cmlink_pkg.sv
// Camera Link Base transmitter shared definitions: lane geometry, clock
// pattern and the Channel Link port-to-bit mapping used to pack a word.
package cmlink_pkg;

    localparam int CMLINK_LANES = 4;
    localparam int CMLINK_BITS  = 7;
    localparam int CMLINK_WBITS = CMLINK_LANES * CMLINK_BITS;

    localparam logic [CMLINK_BITS-1:0] CLK_PATTERN = 7'b1100011;

    // Source index codes into the packed source vector:
    // 0..7 = A0..A7, 8..15 = B0..B7, 16..23 = C0..C7,
    // 24 = LVAL, 25 = FVAL, 26 = DVAL, 27 = constant 0 (spare).
    localparam logic [4:0] SRC_ZERO = 5'd27;

    localparam logic [4:0] W_MAP [0:CMLINK_WBITS-1] = '{
        5'd0,  5'd1,  5'd2,  5'd3,  5'd4,  5'd7,  5'd5,
        5'd8,  5'd9,  5'd10, 5'd14, 5'd15, 5'd11, 5'd12,
        5'd13, 5'd16, 5'd22, 5'd23, 5'd17, 5'd18, 5'd19,
        5'd20, 5'd21, SRC_ZERO, 5'd24, 5'd25, 5'd26, 5'd6
    };

    function automatic logic [CMLINK_WBITS-1:0] cmlink_pack(
        input logic [7:0] a,
        input logic [7:0] b,
        input logic [7:0] c,
        input logic       fval,
        input logic       lval,
        input logic       dval
    );
        logic [27:0]             src;
        logic [CMLINK_WBITS-1:0] w;
        src = {1'b0, dval, fval, lval, c, b, a};
        w   = '0;
        for (int i = 0; i < CMLINK_WBITS; i++) begin
            w[i] = src[W_MAP[i]];
        end
        return w;
    endfunction

endpackage

// File: rtl/cmlink_lane_ser.sv
// One serial lane: 7-bit parallel load, shift left, MSB out.
// Zero fill on shift so an unloaded lane drains to 0.
module cmlink_lane_ser
    import cmlink_pkg::*;
(
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_load,
    input  logic [CMLINK_BITS-1:0] i_word,
    output logic                   o_ser
);

    logic [CMLINK_BITS-1:0] r_sh;

    // Load a fresh word at the period boundary, otherwise shift out.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sh <= '0;
        end else if (i_load) begin
            r_sh <= i_word;
        end else begin
            r_sh <= {r_sh[CMLINK_BITS-2:0], 1'b0};
        end
    end

    assign o_ser = r_sh[CMLINK_BITS-1];

endmodule

// File: rtl/cmlink_tx_serializer.sv
// Camera Link Base Channel Link serializer on the 7x bit clock.
// Optional macro CMLINK_DIFF_OUT_EN adds complemented lane outputs.
module cmlink_tx_serializer
    import cmlink_pkg::*;
(
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_fvld,
    input  logic                    i_lvld,
    input  logic                    i_dvld,
    input  logic [7:0]              i_porta,
    input  logic [7:0]              i_portb,
    input  logic [7:0]              i_portc,
    output logic                    o_load,
`ifdef CMLINK_DIFF_OUT_EN
    output logic                    o_cmlink_clk_n,
    output logic [CMLINK_LANES-1:0] o_cmlink_data_n,
`endif
    output logic                    o_cmlink_clk,
    output logic [CMLINK_LANES-1:0] o_cmlink_data
);

    logic [2:0]              r_slot;
    logic                    w_load;
    logic [CMLINK_WBITS-1:0] w_word;

    assign w_load = (r_slot == 3'd6);
    assign o_load = w_load;

    // Inputs only matter at the load edge; packing is purely combinational.
    assign w_word = cmlink_pack(i_porta, i_portb, i_portc,
                                i_fvld, i_lvld, i_dvld);

    // Slot counter walks 0..6 and wraps at each load edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_slot <= 3'd0;
        end else if (w_load) begin
            r_slot <= 3'd0;
        end else begin
            r_slot <= r_slot + 3'd1;
        end
    end

    for (genvar k = 0; k < CMLINK_LANES; k++) begin : g_lane
        cmlink_lane_ser u_lane (
            .i_clk  (i_clk),
            .i_rst  (i_rst),
            .i_load (w_load),
            .i_word (w_word[k*CMLINK_BITS +: CMLINK_BITS]),
            .o_ser  (o_cmlink_data[k])
        );
    end

    cmlink_lane_ser u_clk_lane (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_load (w_load),
        .i_word (CLK_PATTERN),
        .o_ser  (o_cmlink_clk)
    );

`ifdef CMLINK_DIFF_OUT_EN
    assign o_cmlink_clk_n  = ~o_cmlink_clk;
    assign o_cmlink_data_n = ~o_cmlink_data;
`endif

endmodule

// File: tb/tb_cmlink_tx_serializer.sv
// Directed bench for cmlink_tx_serializer; honours CMLINK_DIFF_OUT_EN.
// Vector table of packed words plus reset/load-timing sequences.
module tb_cmlink_tx_serializer;

    logic       clk = 1'b0;
    logic       rst;
    logic       fv, lv, dv;
    logic [7:0] pa, pb, pc;
    logic       load;
    logic       sclk;
    logic [3:0] sdat;
`ifdef CMLINK_DIFF_OUT_EN
    logic       sclk_n;
    logic [3:0] sdat_n;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    cmlink_tx_serializer dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_fvld        (fv),
        .i_lvld        (lv),
        .i_dvld        (dv),
        .i_porta       (pa),
        .i_portb       (pb),
        .i_portc       (pc),
        .o_load        (load),
`ifdef CMLINK_DIFF_OUT_EN
        .o_cmlink_clk_n  (sclk_n),
        .o_cmlink_data_n (sdat_n),
`endif
        .o_cmlink_clk  (sclk),
        .o_cmlink_data (sdat)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  a, b, c;
        logic        f, l, d;
        logic [27:0] w;
    } vec_t;

    vec_t vt [10];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_quiet(input string nm);
        chk({nm, "_data"}, {28'd0, sdat}, 32'd0);
        chk({nm, "_clk"}, {31'd0, sclk}, 32'd0);
`ifdef CMLINK_DIFF_OUT_EN
        chk({nm, "_datan"}, {28'd0, sdat_n}, 32'hF);
`endif
    endtask

    task automatic set_in(input vec_t v);
        pa = v.a; pb = v.b; pc = v.c;
        fv = v.f; lv = v.l; dv = v.d;
    endtask

    task automatic run_vec(input int idx);
        logic [6:0] lw [4];
        logic [6:0] cw;
        int         guard;
        string      nm;
        guard = 0;
        while (load !== 1'b1 && guard < 8) begin
            tick();
            guard++;
        end
        chk($sformatf("v%0d_loadwait", idx), {31'd0, load}, 32'd1);
        set_in(vt[idx]);
        tick();
        // Garbage between load edges must not disturb the word.
        pa = ~vt[idx].a; pb = ~vt[idx].b; pc = ~vt[idx].c;
        fv = ~vt[idx].f; lv = ~vt[idx].l; dv = ~vt[idx].d;
        for (int s = 0; s < 7; s++) begin
            for (int k = 0; k < 4; k++) lw[k][6-s] = sdat[k];
            cw[6-s] = sclk;
`ifdef CMLINK_DIFF_OUT_EN
            chk($sformatf("v%0d_s%0d_diff", idx, s),
                {27'd0, sclk_n, sdat_n}, {27'd0, ~sclk, ~sdat});
`endif
            if (s < 6) tick();
        end
        for (int k = 0; k < 4; k++) begin
            nm = $sformatf("v%0d_lane%0d", idx, k);
            chk(nm, {25'd0, lw[k]}, {25'd0, vt[idx].w[7*k +: 7]});
        end
        chk($sformatf("v%0d_clklane", idx), {25'd0, cw}, 32'h63);
    endtask

    initial begin
        //            a      b      c      f     l     d     w
        vt[0] = '{8'h01, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 28'h0000001};
        vt[1] = '{8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 28'h2000000};
        vt[2] = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 28'h1000000};
        vt[3] = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 28'h4000000};
        vt[4] = '{8'h40, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 28'h8000000};
        vt[5] = '{8'h00, 8'h00, 8'h40, 1'b0, 1'b0, 1'b0, 28'h0010000};
        vt[6] = '{8'h80, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 28'h0000020};
        vt[7] = '{8'h00, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 28'h0007F80};
        vt[8] = '{8'hAA, 8'h55, 8'h0F, 1'b0, 1'b0, 1'b0, 28'h01CA6EA};
        vt[9] = '{8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b1, 1'b1, 28'hF7FFFFF};

        rst = 1'b1;
        pa = 8'hFF; pb = 8'hFF; pc = 8'hFF;
        fv = 1'b1; lv = 1'b1; dv = 1'b1;

        // Reset hold with busy inputs.
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_quiet($sformatf("rst%0d", i));
            chk($sformatf("rst%0d_load", i), {31'd0, load}, 32'd0);
        end

        // Release: first load in the 7th post-reset cycle.
        rst = 1'b0;
        chk_quiet("rel0");
        chk("rel0_load", {31'd0, load}, 32'd0);
        for (int i = 1; i <= 6; i++) begin
            tick();
            chk($sformatf("rel%0d_load", i), {31'd0, load},
                {31'd0, (i == 6)});
            chk_quiet($sformatf("rel%0d", i));
        end

        // Load strobe recurs every 7 cycles exactly.
        for (int i = 1; i <= 21; i++) begin
            tick();
            chk($sformatf("per%0d_load", i), {31'd0, load},
                {31'd0, (i % 7 == 0)});
        end

        for (int v = 0; v < 10; v++) run_vec(v);

        // Mid-period reset at slot 3 with all-ones input.
        set_in(vt[9]);
        tick();
        tick(); tick(); tick();
        chk("mid_s3_data", {28'd0, sdat}, 32'hF);
        rst = 1'b1;
        tick();
        chk_quiet("mid_rst");
        chk("mid_rst_load", {31'd0, load}, 32'd0);
        rst = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            chk($sformatf("mid%0d_load", i), {31'd0, load},
                {31'd0, (i == 6)});
            chk_quiet($sformatf("mid%0d", i));
        end
        tick();
        chk("mid_reload_data", {28'd0, sdat}, 32'hF);
        chk("mid_reload_clk", {31'd0, sclk}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
